// File: rtl/serializador_carga_paralela.sv
// Parallel-load, serial-out stage feeding the 4-bit serial-in shift register.
// Latency: the first bit appears on out one edge after the load is accepted, then one bit per clock.
// Backpressure: pronto is high when idle and in the last-bit cycle; a load while pronto=0 is ignored.
//
// Ports:
//   clock       - system clock; all state updates on the rising edge
//   reset       - synchronous, active-high; overrides carrega
//   dado        - parallel word, sampled only on an accepted load
//   carrega     - load request
//   pronto      - ready for a new word this cycle (combinational)
//   out         - serial data bit (registered)
//   valido      - out carries a data bit this cycle (registered)
//   fim_palavra - out carries the last bit of a word (registered)
module serializador_carga_paralela #(
  parameter int LARGURA      = 4,
  parameter bit MSB_PRIMEIRO = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] dado,
  input  logic               carrega,
  output logic               pronto,
  output logic               out,
  output logic               valido,
  output logic               fim_palavra
);

  localparam int            CW     = $clog2(LARGURA);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  typedef enum logic {OCIOSO, DESLOCA} estado_t;

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               valido_q, valido_d;
  logic               fim_q, fim_d;

  logic ultimo_bit;
  logic aceita;

  // The last-bit cycle doubles as a load slot so words can chain with no gap.
  assign ultimo_bit = (state_q == DESLOCA) && (cnt_q == ULTIMO);
  assign pronto     = (state_q == OCIOSO) || ultimo_bit;
  assign aceita     = carrega && pronto;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (aceita) state_d = DESLOCA;
      DESLOCA: if (ultimo_bit && !aceita) state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Output / datapath next values. Defaults are the idle values, so leaving
  // the last-bit cycle without a new load drops out/valido/fim to zero.
  // sr holds only the bits not yet sent: the first bit goes straight to out
  // on the load edge and the word is stored already shifted by one.
  always_comb begin
    sr_d     = '0;
    cnt_d    = '0;
    out_d    = 1'b0;
    valido_d = 1'b0;
    fim_d    = 1'b0;
    if (aceita) begin
      valido_d = 1'b1;
      if (MSB_PRIMEIRO) begin
        out_d = dado[LARGURA-1];
        sr_d  = dado << 1;
      end else begin
        out_d = dado[0];
        sr_d  = dado >> 1;
      end
    end else if ((state_q == DESLOCA) && !ultimo_bit) begin
      valido_d = 1'b1;
      cnt_d    = cnt_q + CW'(1);
      fim_d    = (cnt_q == (ULTIMO - CW'(1)));
      if (MSB_PRIMEIRO) begin
        out_d = sr_q[LARGURA-1];
        sr_d  = sr_q << 1;
      end else begin
        out_d = sr_q[0];
        sr_d  = sr_q >> 1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      valido_q <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valido_q <= valido_d;
      fim_q    <= fim_d;
    end
  end

  assign out         = out_q;
  assign valido      = valido_q;
  assign fim_palavra = fim_q;

endmodule
